// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Reads words from a synchronous FIFO (one-cycle read latency) and presents
// them as a ready/valid stream through a 2-entry in-order skid buffer. Reads
// are issued only when the words already buffered, plus the one in flight,
// minus the one leaving this cycle, leave room. The buffer therefore never
// overflows, and a full pipeline still sustains one beat per cycle.
//
// Optional feature: define FIFO_STREAM_READER_BURST_EN to build the beat
// counter, m_last and burst_count. Without it, m_last and burst_count are
// tied to 0 and the data path is identical.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           burst_count
);

    // Buffer state: occupancy 0..2, entry0 is the oldest word
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;

    // Read issued last cycle; its word shows up on fifo_valid this cycle
    logic                  inflight_p1;

    // Low for the first edge after reset so a stale fifo_valid is dropped
    logic                  armed;

    logic                  pop;
    logic                  push;
    logic [2:0]            credit;

    assign m_valid = (occ != 2'd0);
    assign m_data  = entry0;
    assign pop     = m_valid & m_ready;
    assign push    = fifo_valid & armed;

    // Read strobe: issue only if the word would have a free slot on arrival
    always_comb begin
        credit     = {1'b0, occ} + {2'b00, inflight_p1} - {2'b00, pop};
        fifo_rd_en = ~reset & enable & ~fifo_empty & (credit < 3'd2);
    end

    // Control: occupancy, in-flight read flag and post-reset arming
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ         <= 2'd0;
            inflight_p1 <= 1'b0;
            armed       <= 1'b0;
        end else begin
            inflight_p1 <= fifo_rd_en;
            armed       <= 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Data: shift on pop, new word lands behind the surviving oldest word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
        end else if (pop) begin
            entry0 <= (push && occ == 2'd1) ? fifo_dout : entry1;
            if (push && occ == 2'd2) begin
                entry1 <= fifo_dout;
            end
        end else if (push) begin
            if (occ == 2'd0) begin
                entry0 <= fifo_dout;
            end else begin
                entry1 <= fifo_dout;
            end
        end
    end

`ifdef FIFO_STREAM_READER_BURST_EN
    localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

    logic [15:0] beat_cnt;

    assign m_last = m_valid && (beat_cnt == LAST_BEAT);

    // Burst tracking: beat position within the burst and completed bursts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_cnt    <= 16'd0;
            burst_count <= 16'd0;
        end else if (pop) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? 16'd0 : beat_cnt + 16'd1;
            if (m_last) begin
                burst_count <= burst_count + 16'd1;
            end
        end
    end
`else
    // Burst length only matters when the burst logic is built
    logic burst_len_unused;
    assign burst_len_unused = (BURST_LEN > 1);

    assign m_last      = 1'b0;
    assign burst_count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: behavioural sync FIFO, per-beat
// monitor, a cycle table for the back-pressure sequence and directed
// sequences for throughput, stalls, bursts and reset.
module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int BL = 16;
`ifdef FIFO_STREAM_READER_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          fifo_valid;
    logic [DW-1:0] fifo_dout;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [15:0]   burst_count;

    always #5 clock = ~clock;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_valid  (fifo_valid),
        .fifo_dout   (fifo_dout),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .burst_count (burst_count)
    );

    // Behavioural synchronous FIFO with one-cycle read latency
    logic [DW-1:0] mem [0:127];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          model_valid = 1'b0;
    logic [DW-1:0] model_dout = '0;
    logic          inject = 1'b0;
    logic [DW-1:0] inj_data = '0;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_valid = model_valid | inject;
    assign fifo_dout  = inject ? inj_data : model_dout;

    always @(posedge clock) begin
        if (fifo_rd_en && !fifo_empty) begin
            model_dout  <= mem[rd_ptr & 127];
            model_valid <= 1'b1;
            rd_ptr      <= rd_ptr + 1;
        end else begin
            model_valid <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: beat order, m_last, stall stability, credit limit
    int            cyc = 0;
    int            beat_total = 0;
    int            last_total = 0;
    int            last_pos = 0;
    int            outstanding = 0;
    int            exp_ptr = 0;
    int            bm_cnt = 0;
    int            first_rd_cyc = -1;
    int            first_vld_cyc = -1;
    int            first_beat_cyc = -1;
    int            last_beat_cyc = -1;
    logic [DW-1:0] first_beat_data = '0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_stall = 1'b0;
    logic          prev_last = 1'b0;
    logic          mon_pop;
    logic          exp_last;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            beat_total     = 0;
            last_total     = 0;
            last_pos       = 0;
            outstanding    = 0;
            exp_ptr        = rd_ptr;
            bm_cnt         = 0;
            first_rd_cyc   = -1;
            first_vld_cyc  = -1;
            first_beat_cyc = -1;
            last_beat_cyc  = -1;
            prev_stall     = 1'b0;
        end else begin
            mon_pop = m_valid && m_ready;
            if (fifo_rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (fifo_rd_en) begin
                check("credit_limit", ((outstanding - (mon_pop ? 1 : 0)) < 2) ? 1 : 0, 1);
            end
            if (mon_pop) begin
                exp_last = BURST_ON && (bm_cnt == BL - 1);
                check("beat_data", m_data, mem[exp_ptr & 127]);
                check("beat_last", m_last, exp_last);
                if (beat_total == 0) begin
                    first_beat_cyc  = cyc;
                    first_beat_data = m_data;
                end
                last_beat_cyc = cyc;
                exp_ptr++;
                beat_total++;
                if (m_last) begin
                    last_total++;
                    last_pos = beat_total;
                end
                bm_cnt = (bm_cnt == BL - 1) ? 0 : bm_cnt + 1;
            end
            outstanding += (fifo_rd_en ? 1 : 0) - (mon_pop ? 1 : 0);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input int n, input logic [15:0] base, input logic [15:0] inc);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr & 127] = base + 16'(inc * i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        repeat (3) step();
    endtask

    task automatic check_zero(input string tag);
        @(negedge clock);
        check({tag, "_rd_en"}, fifo_rd_en, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_burst_count"}, burst_count, 0);
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int k = 0;
        while (beat_total < n && k < budget) begin
            step();
            k++;
        end
        check(name, beat_total, n);
    endtask

    typedef struct {
        logic          en;
        logic          rdy;
        logic          exp_rd;
        logic          exp_vld;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [11];

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;

        // Cycle table: 4 words, stall until occupancy 2, then drain
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hA000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hA000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hA000};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hA000};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'hA001};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hA002};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hA003};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hA003};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};

        // Reset state, with enable high and FIFO non-empty
        do_reset();
        preload(4, 16'hA000, 16'h0001);
        enable = 1'b1;
        check_zero("reset");
        step();

        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            enable  = tbl[i].en;
            m_ready = tbl[i].rdy;
            @(negedge clock);
            check($sformatf("tbl%0d_rd_en", i), fifo_rd_en, tbl[i].exp_rd);
            check($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].exp_vld);
            if (tbl[i].exp_vld) check($sformatf("tbl%0d_m_data", i), m_data, tbl[i].exp_data);
            step();
        end

        // Stale fifo_valid on the first edge after reset release is dropped
        do_reset();
        reset    = 1'b0;
        inject   = 1'b1;
        inj_data = 16'hDEAD;
        step();
        inject = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_reset_stale_valid", m_valid, 0);
            step();
        end

        // 16-word stream at full rate
        do_reset();
        preload(16, 16'h0123, 16'h0101);
        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_beats(16, 60, "full_rate_beats");
        check("full_rate_latency", first_vld_cyc - first_rd_cyc, 2);
        check("full_rate_throughput", last_beat_cyc - first_beat_cyc, 15);
        check("full_rate_first", first_beat_data, 16'h0123);
        check("full_rate_last_count", last_total, BURST_ON ? 1 : 0);
        check("full_rate_last_pos", last_pos, BURST_ON ? 16 : 0);
        check("full_rate_bursts", burst_count, BURST_ON ? 1 : 0);
        repeat (3) step();
        check("full_rate_no_extra", beat_total, 16);
        check("full_rate_idle", m_valid, 0);

        // Same stream, m_ready toggling every cycle
        do_reset();
        preload(16, 16'h0123, 16'h0101);
        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 100 && beat_total < 16; k++) begin
            step();
            m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        repeat (3) step();
        check("toggle_beats", beat_total, 16);
        check("toggle_bursts", burst_count, BURST_ON ? 1 : 0);

        // 40 words: two full bursts plus 8 beats
        do_reset();
        preload(40, 16'h4000, 16'h0001);
        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_beats(40, 120, "burst40_beats");
        check("burst40_last_count", last_total, BURST_ON ? 2 : 0);
        check("burst40_last_pos", last_pos, BURST_ON ? 32 : 0);
        check("burst40_bursts", burst_count, BURST_ON ? 2 : 0);

        // Reset with a word buffered and a read in flight
        do_reset();
        preload(6, 16'h5000, 16'h0001);
        reset   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_zero($sformatf("mid_reset%0d", i));
            step();
        end
        reset   = 1'b0;
        m_ready = 1'b1;
        wait_beats(4, 30, "mid_reset_beats");
        check("mid_reset_first", first_beat_data, 16'h5002);
        repeat (3) step();
        check("mid_reset_no_extra", beat_total, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
